// File: rtl/mdu_hilo.sv
// ============================================================================
// mdu_hilo : iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional MDU_DIV0_FLAG_EN adds oDivZero. Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iHiWe,
  input  logic             iLoWe,
  input  logic [WIDTH-1:0] iWData,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             oDivZero
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a_in, b_in, opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_lo, neg_hi;

  logic               is_div, is_signed, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iStart) state_next = PREP;
      PREP:    state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    is_div    = op[1];
    is_signed = ~op[0];
    a_neg     = is_signed & a_in[WIDTH-1];
    b_neg     = is_signed & b_in[WIDTH-1];
    mag_a     = a_neg ? -a_in : a_in;
    mag_b     = b_neg ? -b_in : b_in;
    div_zero  = is_div & (b_in == '0);
    // multiply: acc = {partial product, remaining multiplier bits}
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // divide: acc = {remainder, unconsumed dividend / growing quotient}
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    prod      = neg_lo ? -acc : acc;
    quo       = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = a_in;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      a_in   <= '0;
      b_in   <= '0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
      oHi    <= '0;
      oLo    <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iHiWe) oHi <= iWData;
          if (iLoWe) oLo <= iWData;
          if (iStart) begin
            op    <= iOp;
            a_in  <= iA;
            b_in  <= iB;
            oBusy <= 1'b1;
          end
        end
        PREP: begin
          cnt    <= '0;
          neg_lo <= a_neg ^ b_neg;
          neg_hi <= a_neg;
          opnd   <= is_div ? mag_b : mag_a;
          acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH+1])
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
              acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else if (acc[0]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        FIX: begin
          oHi   <= fix_hi;
          oLo   <= fix_lo;
          oBusy <= 1'b0;
          oDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)               oDivZero <= 1'b0;
    else if (state == FIX) oDivZero <= div_zero;
    else                   oDivZero <= 1'b0;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: random and directed ops against an
// arithmetic reference model; a monitor checks every completion pulse.
`default_nettype none

module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk(clk), .rst(rst), .iStart(start), .iOp(op), .iA(a), .iB(b),
    .iHiWe(hi_we), .iLoWe(lo_we), .iWData(wdata),
    .oBusy(busy), .oDone(done), .oHi(hi), .oLo(lo)
`ifdef MDU_DIV0_FLAG_EN
    , .oDivZero(div_zero)
`endif
  );

`ifndef MDU_DIV0_FLAG_EN
  assign div_zero = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics via plain 64-bit arithmetic.
  function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = o[1] && (y == 0);
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
`ifndef MDU_DIV0_FLAG_EN
    e.dz = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("div_zero_flag", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  // Entered just after a negedge; returns at the negedge of the oDone cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke_busy, input bit mt_with_start);
    exp_t e;
    e = ref_model(o, x, y);
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    if (mt_with_start) begin
      lo_we = 1'b1;
      wdata = $urandom;
      cur_lo = wdata;
    end
    @(posedge clk);
    #1 start = 1'b0; lo_we = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_rise", {31'd0, busy}, 32'd1);
      if (poke_busy && k == 10) begin
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (poke_busy && k == 11) begin
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
      end
      if (k == 34) begin
        check("busy_last", {31'd0, busy}, 32'd1);
        check("done_early", {31'd0, done}, 32'd0);
        check("hold_hi", hi, cur_hi);
        check("hold_lo", lo, cur_lo);
      end
      if (k == 35) begin
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
      end
    end
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] d);
    wdata = d;
    if (to_hi) hi_we = 1'b1; else lo_we = 1'b1;
    @(posedge clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    if (to_hi) begin
      cur_hi = d;
      check("mthi", hi, d);
    end else begin
      cur_lo = d;
      check("mtlo", lo, d);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials[6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300)) - 32'd150;
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(2'd3, 32'd100, 32'd7, 0, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd3, 32'd5, 32'd0, 0, 0);
    run_op(2'd3, 32'd5, 32'd1, 0, 0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, 0);

    @(negedge clk);
    mt_write(1, 32'h0000_1234);
    mt_write(0, 32'h0000_5678);
    run_op(2'd1, 32'd2, 32'd3, 1, 0);
    check("poke_final_hi", hi, 32'd0);
    check("poke_final_lo", lo, 32'd6);
    run_op(2'd0, 32'h1234_5678, 32'h8765_4321, 0, 1);

    // reset mid-operation: no result, no late pulse
    @(negedge clk);
    op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    cur_hi = '0;
    cur_lo = '0;
    repeat (40) @(negedge clk);
    run_op(2'd1, 32'd4, 32'd5, 0, 0);
    check("after_rst_lo", lo, 32'd20);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap == 2) mt_write(bit'($urandom_range(0, 1)), $urandom);
      else if (gap == 1) @(negedge clk);
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 0,
             $urandom_range(0, 4) == 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
